// File: rtl/shift_arbiter_if.sv
// Bundle between two shift requesters, the shared shifter
// and the tagged response consumer.
interface shift_arbiter_if #(
  parameter int DW = 16,
  parameter int SW = 5
);
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_data;
  logic          req0_dir;
  logic [2:0]    req0_func;
  logic [SW-1:0] req0_shamt;

  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_data;
  logic          req1_dir;
  logic [2:0]    req1_func;
  logic [SW-1:0] req1_shamt;

  logic [DW-1:0] sh_data_in;
  logic          sh_dir;
  logic [2:0]    sh_func;
  logic [SW-1:0] sh_shamt;
  logic [DW-1:0] sh_data_out;
  logic [3:0]    sh_flag;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic [3:0]    rsp_flag;
  logic          rsp_err;

  modport slave (
    input  req0_valid, req0_data, req0_dir,
    input  req0_func, req0_shamt,
    output req0_ready,
    input  req1_valid, req1_data, req1_dir,
    input  req1_func, req1_shamt,
    output req1_ready,
    output sh_data_in, sh_dir, sh_func, sh_shamt,
    input  sh_data_out, sh_flag,
    output rsp_valid, rsp_id, rsp_data,
    output rsp_flag, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_data, req0_dir,
    output req0_func, req0_shamt,
    input  req0_ready,
    output req1_valid, req1_data, req1_dir,
    output req1_func, req1_shamt,
    input  req1_ready,
    input  sh_data_in, sh_dir, sh_func, sh_shamt,
    output sh_data_out, sh_flag,
    input  rsp_valid, rsp_id, rsp_data,
    input  rsp_flag, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin share of one combinational shifter between
// two requesters, with an ID-tagged valid/ready response.
module shift_arbiter #(
  parameter int DW = 16,
  parameter int SW = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          last_q;
  logic          gnt0;
  logic          gnt1;
  logic          acc;
  logic          legal;

  logic [DW-1:0] sel_data;
  logic          sel_dir;
  logic [2:0]    sel_func;
  logic [SW-1:0] sel_shamt;

  logic [DW-1:0] sh_data_q;
  logic          sh_dir_q;
  logic [2:0]    sh_func_q;
  logic [SW-1:0] sh_shamt_q;

  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_data_q;
  logic [3:0]    rsp_flag_q;
  logic          rsp_err_q;

  // On a tie, serve whoever was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      bus.req0_valid && bus.req1_valid: begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end
      bus.req0_valid && !bus.req1_valid:
        gnt0 = 1'b1;
      !bus.req0_valid && bus.req1_valid:
        gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign bus.req0_ready = (state_q == IDLE) && gnt0;
  assign bus.req1_ready = (state_q == IDLE) && gnt1;

  assign acc = (bus.req0_valid && bus.req0_ready)
            || (bus.req1_valid && bus.req1_ready);

  always_comb begin
    sel_data  = bus.req0_data;
    sel_dir   = bus.req0_dir;
    sel_func  = bus.req0_func;
    sel_shamt = bus.req0_shamt;
    if (gnt1) begin
      sel_data  = bus.req1_data;
      sel_dir   = bus.req1_dir;
      sel_func  = bus.req1_func;
      sel_shamt = bus.req1_shamt;
    end
  end

  // Exactly one-hot function codes are legal.
  always_comb begin
    legal = 1'b0;
    unique case (sel_func)
      3'b100, 3'b010, 3'b001: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc) state_d = legal ? EXEC : RESP;
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q      <= 1'b1;
      sh_data_q   <= '0;
      sh_dir_q    <= 1'b0;
      sh_func_q   <= 3'b000;
      sh_shamt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 4'b0000;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && acc) begin
        last_q   <= gnt1;
        rsp_id_q <= gnt1;
        if (legal) begin
          sh_data_q  <= sel_data;
          sh_dir_q   <= sel_dir;
          sh_func_q  <= sel_func;
          sh_shamt_q <= sel_shamt;
        end else begin
          // Shifter stays on the previous op; operand echoes back.
          rsp_data_q  <= sel_data;
          rsp_flag_q  <= 4'b0000;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= 1'b1;
        end
      end
      if (state_q == EXEC) begin
        rsp_data_q  <= bus.sh_data_out;
        rsp_flag_q  <= bus.sh_flag;
        rsp_err_q   <= 1'b0;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.sh_data_in = sh_data_q;
  assign bus.sh_dir     = sh_dir_q;
  assign bus.sh_func    = sh_func_q;
  assign bus.sh_shamt   = sh_shamt_q;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_flag   = rsp_flag_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed scoreboard bench for shift_arbiter with a
// behavioural 16-bit shifter on the sh_* side.
module tb_shift_arbiter;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic [3:0]  flag;
    logic        err;
  } rsp_t;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;
  int   n_rsp;
  rsp_t sb[$];

  shift_arbiter_if #(.DW(16), .SW(5)) bus ();

  shift_arbiter #(.DW(16), .SW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter: C is the last bit shifted/rotated out,
  // V flags a sign change on an arithmetic left shift.
  function automatic logic [19:0] shf(
    input logic [15:0] d,
    input logic        dir,
    input logic [2:0]  f,
    input logic [4:0]  s
  );
    logic [15:0] r;
    logic        c;
    logic        v;
    r = d;
    c = 1'b0;
    v = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(s)) begin
        if (dir) begin
          c = r[0];
          if (f == 3'b100)      r = {1'b0, r[15:1]};
          else if (f == 3'b010) r = {r[15], r[15:1]};
          else                  r = {r[0], r[15:1]};
        end else begin
          c = r[15];
          if (f == 3'b001) r = {r[14:0], r[15]};
          else             r = {r[14:0], 1'b0};
          if (f == 3'b010 && r[15] != c) v = 1'b1;
        end
      end
    end
    return {r, (r == 16'h0), r[15], c, v};
  endfunction

  always_comb begin
    {bus.sh_data_out, bus.sh_flag} =
      shf(bus.sh_data_in, bus.sh_dir,
          bus.sh_func, bus.sh_shamt);
  end

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response handshake.
  always begin
    @(negedge clk);
    #3;
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_id",   32'(bus.rsp_id),   32'(e.id));
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_flag", 32'(bus.rsp_flag), 32'(e.flag));
        check("rsp_err",  32'(bus.rsp_err),  32'(e.err));
      end
    end
    if (bus.req0_ready && bus.req1_ready)
      check("two_readys", 32'd1, 32'd0);
  end

  task automatic drive(
    input int          n,
    input logic        v,
    input logic [15:0] d,
    input logic        dir,
    input logic [2:0]  f,
    input logic [4:0]  s
  );
    if (n == 0) begin
      bus.req0_valid = v;
      bus.req0_data  = d;
      bus.req0_dir   = dir;
      bus.req0_func  = f;
      bus.req0_shamt = s;
    end else begin
      bus.req1_valid = v;
      bus.req1_data  = d;
      bus.req1_dir   = dir;
      bus.req1_func  = f;
      bus.req1_shamt = s;
    end
  endtask

  // Called at a negedge with the arbiter idle and rsp_ready=1.
  task automatic run_op(
    input int          n,
    input logic [15:0] d,
    input logic        dir,
    input logic [2:0]  f,
    input logic [4:0]  s,
    input rsp_t        e,
    input int          lat
  );
    int k;
    drive(n, 1'b1, d, dir, f, s);
    #1;
    if (n == 0) check("req0_ready", 32'(bus.req0_ready), 32'd1);
    else        check("req1_ready", 32'(bus.req1_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    drive(n, 1'b0, d, dir, f, s);
    k = 1;
    while (!bus.rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    k = 0;
    while (bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [15:0] op_d[2][2];
  logic        op_r[2][2];
  logic [2:0]  op_f[2][2];
  logic [4:0]  op_s[2][2];
  rsp_t        op_e[2][2];

  initial begin
    rsp_t snap;
    int   idx[2];
    int   acc_n;
    int   cyc;
    int   eg;
    int   g;
    int   rsp0;

    n_chk   = 0;
    n_fail  = 0;
    n_rsp   = 0;
    reset_n = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(0, 1'b0, 16'h0, 1'b0, 3'b000, 5'd0);
    drive(1, 1'b0, 16'h0, 1'b0, 3'b000, 5'd0);

    op_d[0][0] = 16'h00F0; op_r[0][0] = 1'b1;
    op_f[0][0] = 3'b100;   op_s[0][0] = 5'd4;
    op_e[0][0] = '{1'b0, 16'h000F, 4'b0000, 1'b0};
    op_d[0][1] = 16'h0003; op_r[0][1] = 1'b0;
    op_f[0][1] = 3'b100;   op_s[0][1] = 5'd1;
    op_e[0][1] = '{1'b0, 16'h0006, 4'b0000, 1'b0};
    op_d[1][0] = 16'hFFFF; op_r[1][0] = 1'b1;
    op_f[1][0] = 3'b010;   op_s[1][0] = 5'd3;
    op_e[1][0] = '{1'b1, 16'hFFFF, 4'b0110, 1'b0};
    op_d[1][1] = 16'h4000; op_r[1][1] = 1'b0;
    op_f[1][1] = 3'b010;   op_s[1][1] = 5'd1;
    op_e[1][1] = '{1'b1, 16'h8000, 4'b0101, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp", {bus.rsp_id, bus.rsp_data,
          bus.rsp_flag, bus.rsp_err}, 32'd0);
    check("rst_sh", {bus.sh_data_in, bus.sh_dir,
          bus.sh_func, bus.sh_shamt}, 32'd0);
    reset_n = 1'b1;

    run_op(0, 16'h8010, 1'b1, 3'b100, 5'd4,
           '{1'b0, 16'h0801, 4'b0000, 1'b0}, 2);
    run_op(1, 16'h8000, 1'b1, 3'b010, 5'd1,
           '{1'b1, 16'hC000, 4'b0100, 1'b0}, 2);
    run_op(0, 16'h0001, 1'b0, 3'b100, 5'd16,
           '{1'b0, 16'h0000, 4'b1010, 1'b0}, 2);
    run_op(1, 16'h8001, 1'b0, 3'b001, 5'd4,
           '{1'b1, 16'h0018, 4'b0000, 1'b0}, 2);
    run_op(0, 16'h1234, 1'b0, 3'b011, 5'd2,
           '{1'b0, 16'h1234, 4'b0000, 1'b1}, 1);
    check("illegal_sh", {bus.sh_data_in, bus.sh_dir,
          bus.sh_func, bus.sh_shamt},
          {16'h8001, 1'b0, 3'b001, 5'd4});

    // Backpressure with both requesters pushing.
    bus.rsp_ready = 1'b0;
    drive(0, 1'b1, 16'hA5A5, 1'b1, 3'b001, 5'd8);
    #1;
    sb.push_back('{1'b0, 16'hA5A5, 4'b0110, 1'b0});
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b1, 16'h1111, 1'b0, 3'b100, 5'd1);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_valid", 32'(bus.rsp_valid), 32'd1);
    snap = '{bus.rsp_id, bus.rsp_data,
             bus.rsp_flag, bus.rsp_err};
    rsp0 = n_rsp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold", {bus.rsp_valid, bus.rsp_id,
            bus.rsp_data, bus.rsp_flag, bus.rsp_err},
            {1'b1, snap});
      check("bp_readys", {bus.req0_ready, bus.req1_ready},
            32'd0);
    end
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 1'b0, 3'b000, 5'd0);
    drive(1, 1'b0, 16'h0, 1'b0, 3'b000, 5'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #4;
    check("bp_one_rsp", 32'(n_rsp - rsp0), 32'd1);
    check("bp_idle", 32'(bus.rsp_valid), 32'd0);

    // Reset while the op is in EXEC.
    @(negedge clk);
    drive(0, 1'b1, 16'h00FF, 1'b0, 3'b100, 5'd4);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b1, 16'h0F0F, 1'b0, 3'b100, 5'd1);
    #1;
    check("exec_readys", {bus.req0_ready, bus.req1_ready},
          32'd0);
    reset_n = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0, 3'b000, 5'd0);
    drive(1, 1'b0, 16'h0, 1'b0, 3'b000, 5'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_sh", {bus.sh_data_in, bus.sh_dir,
          bus.sh_func, bus.sh_shamt}, 32'd0);
    reset_n = 1'b1;

    // Round-robin tie, starting fresh from reset.
    idx[0] = 0;
    idx[1] = 0;
    for (int n = 0; n < 2; n++)
      drive(n, 1'b1, op_d[n][0], op_r[n][0],
            op_f[n][0], op_s[n][0]);
    acc_n = 0;
    cyc   = 0;
    eg    = 0;
    while (acc_n < 4 && cyc < 60) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready ? 1 : 0;
        check("rr_grant", 32'(g), 32'(eg));
        sb.push_back(op_e[g][idx[g]]);
        @(posedge clk);
        @(negedge clk);
        idx[g]++;
        if (idx[g] < 2)
          drive(g, 1'b1, op_d[g][idx[g]], op_r[g][idx[g]],
                op_f[g][idx[g]], op_s[g][idx[g]]);
        else
          drive(g, 1'b0, 16'h0, 1'b0, 3'b000, 5'd0);
        eg = 1 - eg;
        acc_n++;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check("rr_accepts", 32'(acc_n), 32'd4);

    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    #5;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
